// File: rtl/line_draw_pkg.sv
// Shared types, register map and pixel packing for the line-drawing accelerator.
package line_draw_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_INIT = 2'd1,
      ST_PLOT = 2'd2
   } state_e;

   localparam logic [3:0] REG_CTRL   = 4'd0;
   localparam logic [3:0] REG_P0     = 4'd1;
   localparam logic [3:0] REG_P1     = 4'd2;
   localparam logic [3:0] REG_BRIGHT = 4'd3;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   function automatic logic [31:0] pack_pixel(input logic [7:0] x,
                                              input logic [6:0] y,
                                              input logic [7:0] bright);
      return {1'b0, y, x, 8'd0, bright};
   endfunction

endpackage

// File: rtl/line_draw_bresenham_step.sv
// One combinational Bresenham iteration: next x, y and error from the current point.
module bresenham_step #(
   parameter int ERR_W = 11
) (
   input  logic [7:0]              x_i,
   input  logic [6:0]              y_i,
   input  logic signed [ERR_W-1:0] err_i,
   input  logic signed [ERR_W-1:0] dx_i,
   input  logic signed [ERR_W-1:0] dy_i,
   input  logic                    sx_i,
   input  logic                    sy_i,
   output logic [7:0]              x_o,
   output logic [6:0]              y_o,
   output logic signed [ERR_W-1:0] err_o
);

   // One extra bit so 2*err never overflows the comparison.
   logic signed [ERR_W:0] e2_s;
   logic signed [ERR_W:0] dx_ext_s;
   logic signed [ERR_W:0] dy_ext_s;

   assign e2_s     = {err_i, 1'b0};
   assign dx_ext_s = {dx_i[ERR_W-1], dx_i};
   assign dy_ext_s = {dy_i[ERR_W-1], dy_i};

   // Both axis decisions use the pre-step error.
   always_comb begin
      x_o   = x_i;
      y_o   = y_i;
      err_o = err_i;
      if (e2_s >= dy_ext_s) begin
         err_o = err_o + dy_i;
         x_o   = sx_i ? (x_i + 8'd1) : (x_i - 8'd1);
      end else begin
         x_o   = x_i;
      end
      if (e2_s <= dx_ext_s) begin
         err_o = err_o + dx_i;
         y_o   = sy_i ? (y_i + 7'd1) : (y_i - 7'd1);
      end else begin
         y_o   = y_i;
      end
   end

endmodule

// File: rtl/line_draw_avalon.sv
// Avalon-MM line-drawing accelerator: slave config port, Bresenham FSM, one master pixel write per point.
module line_draw_avalon
   import line_draw_pkg::*;
#(
   parameter int M_ADDR_W = 4,
   parameter int ERR_W    = 11
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [3:0]          s_address,
   input  logic                s_read,
   output logic [31:0]         s_readdata,
   input  logic                s_write,
   input  logic [31:0]         s_writedata,
   output logic [M_ADDR_W-1:0] m_address,
   output logic                m_write,
   output logic [31:0]         m_writedata,
   input  logic                m_waitrequest
);

   state_e                 state_q;
   logic [7:0]             x0_q, x1_q, x_q, bright_q;
   logic [6:0]             y0_q, y1_q, y_q;
   logic                   busy_q, done_q, sx_q, sy_q;
   logic signed [ERR_W-1:0] dx_q, dy_q, err_q;
   logic                   m_write_q;
   logic [31:0]            m_writedata_q;

   logic [7:0]             x_d;
   logic [6:0]             y_d;
   logic signed [ERR_W-1:0] err_d;

   logic [7:0]             dx_mag_s;
   logic [6:0]             dy_mag_s;
   logic signed [ERR_W-1:0] dx_init_s, dy_init_s;
   logic                   cfg_wr_s, start_s, accept_s, last_s;
   logic                   unused_s;

   assign cfg_wr_s = s_write & ~busy_q;
   assign start_s  = cfg_wr_s & (s_address == REG_CTRL);
   assign accept_s = m_write_q & ~m_waitrequest;
   assign last_s   = (x_q == x1_q) && (y_q == y1_q);
   assign unused_s = ^{s_read, s_writedata[31], s_writedata[15:8]};

   assign m_address   = {M_ADDR_W{1'b0}};
   assign m_write     = m_write_q;
   assign m_writedata = m_writedata_q;

   // Line setup terms; coordinates are zero-extended before the signed math.
   always_comb begin
      dx_mag_s  = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
      dy_mag_s  = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
      dx_init_s = ERR_W'(dx_mag_s);
      dy_init_s = -(ERR_W'(dy_mag_s));
   end

   bresenham_step #(.ERR_W(ERR_W)) u_step (
      .x_i   (x_q),
      .y_i   (y_q),
      .err_i (err_q),
      .dx_i  (dx_q),
      .dy_i  (dy_q),
      .sx_i  (sx_q),
      .sy_i  (sy_q),
      .x_o   (x_d),
      .y_o   (y_d),
      .err_o (err_d)
   );

   // Zero-latency register readback.
   always_comb begin
      s_readdata = 32'd0;
      case (s_address)
         REG_CTRL:   s_readdata = {30'd0, done_q, busy_q};
         REG_P0:     s_readdata = {1'b0, y0_q, x0_q, 16'd0};
         REG_P1:     s_readdata = {1'b0, y1_q, x1_q, 16'd0};
         REG_BRIGHT: s_readdata = {24'd0, bright_q};
         default:    s_readdata = 32'd0;
      endcase
   end

   // Config registers, control FSM and registered master outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         x0_q          <= 8'd0;
         y0_q          <= 7'd0;
         x1_q          <= 8'd0;
         y1_q          <= 7'd0;
         bright_q      <= 8'd0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         x_q           <= 8'd0;
         y_q           <= 7'd0;
         dx_q          <= '0;
         dy_q          <= '0;
         err_q         <= '0;
         sx_q          <= 1'b0;
         sy_q          <= 1'b0;
         m_write_q     <= 1'b0;
         m_writedata_q <= 32'd0;
      end else begin
         if (cfg_wr_s) begin
            case (s_address)
               REG_P0: begin
                  x0_q <= s_writedata[23:16];
                  y0_q <= s_writedata[30:24];
               end
               REG_P1: begin
                  x1_q <= s_writedata[23:16];
                  y1_q <= s_writedata[30:24];
               end
               REG_BRIGHT: bright_q <= s_writedata[7:0];
               default: ;
            endcase
         end

         case (state_q)
            ST_IDLE: begin
               if (start_s) begin
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  state_q <= ST_INIT;
               end
            end
            ST_INIT: begin
               x_q           <= x0_q;
               y_q           <= y0_q;
               dx_q          <= dx_init_s;
               dy_q          <= dy_init_s;
               err_q         <= dx_init_s + dy_init_s;
               sx_q          <= (x0_q < x1_q);
               sy_q          <= (y0_q < y1_q);
               m_write_q     <= 1'b1;
               m_writedata_q <= pack_pixel(x0_q, y0_q, bright_q);
               state_q       <= ST_PLOT;
            end
            ST_PLOT: begin
               if (accept_s) begin
                  if (last_s) begin
                     m_write_q <= 1'b0;
                     busy_q    <= 1'b0;
                     done_q    <= 1'b1;
                     state_q   <= ST_IDLE;
                  end else begin
                     x_q           <= x_d;
                     y_q           <= y_d;
                     err_q         <= err_d;
                     m_writedata_q <= pack_pixel(x_d, y_d, bright_q);
                  end
               end
            end
            default: begin
               m_write_q <= 1'b0;
               busy_q    <= 1'b0;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/line_draw_avalon.md
Name: line_draw_avalon

Overview:
- Hardware line-drawing accelerator placed directly upstream of the VGA pixel-plot Avalon slave.
- CPU programs endpoints and brightness through an Avalon-MM slave port, then writes START.
- Block runs Bresenham and issues one Avalon-MM master write per pixel, packed in the plot slave's format: {1'b0, y[6:0], x[7:0], 8'd0, brightness[7:0]} at master address 0.
- Throughput is one pixel per clock when the downstream does not stall.

Parameters:
- M_ADDR_W, 4, master address width; address always driven 0.
- ERR_W, 11, signed width of the Bresenham error/difference registers; must hold ±2·255.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- s_address  in  4  slave word address
- s_read  in  1  slave read strobe
- s_readdata  out  32  slave read data (combinational, read latency 0)
- s_write  in  1  slave write strobe
- s_writedata  in  32  slave write data
- m_address  out  M_ADDR_W  master address (constant 0)
- m_write  out  1  master write request
- m_writedata  out  32  packed pixel word
- m_waitrequest  in  1  downstream stall

Behaviour:
- Slave register map:
  - 0 CTRL: write any value = START. Read = {30'b0, done, busy}.
  - 1 P0: x0 = wd[23:16], y0 = wd[30:24].
  - 2 P1: x1 = wd[23:16], y1 = wd[30:24].
  - 3 BRIGHT: wd[7:0].
  - Addresses 4..15: writes ignored, reads return 0.
- Writes to P0/P1/BRIGHT while busy are ignored. START while busy is ignored.
- Reset values: all config registers 0; busy = 0; done = 0; m_write = 0; m_writedata = 0; state = IDLE.
- FSM states: IDLE, INIT, PLOT.
  - IDLE: START sets busy = 1, clears done, goes to INIT.
  - INIT: one cycle. Computes:
    - x = x0, y = y0
    - dx = |x1 - x0|, dy = -|y1 - y0|
    - sx = (x0 < x1) ? +1 : -1; sy likewise
    - err = dx + dy (signed, ERR_W bits; coordinates zero-extended)
  - PLOT: m_write = 1 and m_writedata = {1'b0, y, x, 8'd0, bright}.
    - While m_waitrequest = 1: hold m_write and m_writedata stable.
    - On accept (m_write & !m_waitrequest): if x == x1 and y == y1, go to IDLE with busy = 0, done = 1, and m_write = 0 on the next cycle. Otherwise step:
      - e2 = 2·err
      - if e2 >= dy: err += dy, x += sx
      - if e2 <= dx: err += dx, y += sy
      - both updates use the pre-step err and e2; stay in PLOT.
- Latency: START write at cycle N → INIT at N+1 → first m_write at N+2. An L-pixel line with no stalls completes in L PLOT cycles.
- Degenerate line (P0 == P1) produces exactly one write.
- Out-of-range coordinates (x ≥ 160 or y ≥ 120) are emitted unchanged; the downstream discards them. x and y registers do not wrap, because Bresenham stays within [min, max] of the endpoints.
- done is sticky until the next accepted START.
- Reset asserted mid-line: m_write drops asynchronously, the FSM returns to IDLE, and config registers clear.
- Simultaneous s_write to CTRL and the final accept: the FSM finishes first; START is ignored because busy is still 1 in that cycle.

Decomposition:
- Package line_draw_pkg contains:
  - FSM state enum
  - register address constants (REG_CTRL = 0, REG_P0 = 1, REG_P1 = 2, REG_BRIGHT = 3)
  - screen constants (160, 120)
  - function pack_pixel(x, y, bright) returning the 32-bit plot word
- One sub-module: bresenham_step, a combinational next x/y/err from (x, y, err, dx, dy, sx, sy). It is instantiated once in the top level, which holds the FSM and registers.

Test Plan:
1. P0 = P1 = (50,60), BRIGHT = FF, START → exactly one m_writedata = 32'h3C32_00FF, then done = 1, busy = 0.
2. (10,5)→(14,5), BRIGHT = 80, no stalls → 5 consecutive write cycles starting at N+2, x = 10,11,12,13,14 with y = 5. Reverse (14,5)→(10,5) → x = 14..10.
3. Steep line (0,0)→(2,5) → exactly 6 writes, (x,y) = (0,0),(0,1),(1,2),(1,3),(2,4),(2,5).
4. m_waitrequest high for 3 cycles on the 2nd pixel of scenario 2 → m_write and m_writedata = (11,5) held for 4 cycles; sequence and count unchanged.
5. START and a P1 write issued while busy → both ignored; the line completes with the original endpoints. Reading CTRL mid-line returns 1; after completion it returns 2.
6. Drop reset_n for 1 cycle mid-line → m_write = 0 immediately. After release CTRL reads 0 and no further writes occur.
